// File: rtl/obb_col_pkg.sv
// Shared types and constants for the OBB separating-axis collider.
package obb_col_pkg;

  localparam int POS_W_DEF  = 16;
  localparam int TRIG_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;

  localparam int TRIG_FRAC      = 14;
  localparam int STEPS_PER_AXIS = 8;
  localparam int MAX_LAT        = 34;

  typedef logic signed [POS_W_DEF-1:0]  pos_t;   // Q11.5
  typedef logic signed [TRIG_W_DEF-1:0] trig_t;  // Q1.14

  typedef struct packed {
    pos_t  x;
    pos_t  y;
    pos_t  hw;
    pos_t  hh;
    trig_t cos;
    trig_t sin;
  } box_t;

  typedef enum logic [1:0] {AX_AU, AX_AV, AX_BU, AX_BV} axis_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_AXIS, ST_DONE} state_e;

endpackage

// File: rtl/obb_collider_if.sv
// Request/result bundle between the box registers, the collider and the updater.
interface obb_collider_if #(
  parameter int POS_W  = 16,
  parameter int TRIG_W = 16
);
  logic                     start;
  logic signed [POS_W-1:0]  a_x, a_y, a_hw, a_hh;
  logic signed [POS_W-1:0]  b_x, b_y, b_hw, b_hh;
  logic signed [TRIG_W-1:0] a_cos, a_sin, b_cos, b_sin;
  logic                     busy;
  logic                     done;
  logic                     hit;
  logic [1:0]               axis;
  logic [POS_W-1:0]         depth;

  modport master (
    output start, a_x, a_y, a_hw, a_hh, b_x, b_y, b_hw, b_hh,
           a_cos, a_sin, b_cos, b_sin,
    input  busy, done, hit, axis, depth
  );

  modport slave (
    input  start, a_x, a_y, a_hw, a_hh, b_x, b_y, b_hw, b_hh,
           a_cos, a_sin, b_cos, b_sin,
    output busy, done, hit, axis, depth
  );
endinterface

// File: rtl/sat_mac.sv
// Shared multiply-accumulate: signed product, arithmetic shift by the trig
// fraction, then accumulate into a registered sum with clear and |b| select.
module sat_mac #(
  parameter int A_W   = 17,
  parameter int B_W   = 16,
  parameter int ACC_W = 40,
  parameter int FRAC  = 14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    abs_b,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] acc_nxt
);
  localparam int P_W = A_W + B_W;
  localparam logic signed [B_W-1:0] B_MAX = {1'b0, {(B_W-1){1'b1}}};
  localparam logic signed [B_W-1:0] B_MIN = {1'b1, {(B_W-1){1'b0}}};

  logic signed [B_W-1:0] b_sel;
  logic signed [P_W-1:0] a_ext, b_ext, prod, prod_sh;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    b_sel = b;
    if (abs_b && b[B_W-1]) begin
      b_sel = (b == B_MIN) ? B_MAX : -b;
    end
    a_ext   = {{B_W{a[A_W-1]}}, a};
    b_ext   = {{A_W{b_sel[B_W-1]}}, b_sel};
    prod    = a_ext * b_ext;
    prod_sh = prod >>> FRAC;
    acc_nxt = (clr ? '0 : acc) + {{(ACC_W-P_W){prod_sh[P_W-1]}}, prod_sh};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/obb_collider.sv
// Separating-axis collision test between two oriented boxes, four axes
// evaluated sequentially on one sat_mac; reports hit, min axis and depth.
module obb_collider
  import obb_col_pkg::*;
#(
  parameter int POS_W  = POS_W_DEF,
  parameter int TRIG_W = TRIG_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  obb_collider_if.slave bus
);
  localparam int A_W = POS_W + 1;

  localparam logic signed [TRIG_W-1:0] TRIG_MAX = {1'b0, {(TRIG_W-1){1'b1}}};
  localparam logic signed [TRIG_W-1:0] TRIG_MIN = {1'b1, {(TRIG_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0]  POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  TRIG_HI  = {{(ACC_W-TRIG_W){1'b0}}, TRIG_MAX};
  localparam logic signed [ACC_W-1:0]  TRIG_LO  = {{(ACC_W-TRIG_W){1'b1}}, TRIG_MIN};
  localparam logic signed [ACC_W-1:0]  DEPTH_HI = {{(ACC_W-POS_W){1'b0}}, POS_MAX};

  localparam logic [2:0] S_D    = 3'd2;
  localparam logic [2:0] S_UN   = 3'd4;
  localparam logic [2:0] S_VN   = 3'd6;
  localparam logic [2:0] S_LAST = 3'(STEPS_PER_AXIS - 1);

  typedef struct packed {
    logic signed [POS_W-1:0]  x;
    logic signed [POS_W-1:0]  y;
    logic signed [POS_W-1:0]  hw;
    logic signed [POS_W-1:0]  hh;
    logic signed [TRIG_W-1:0] c;
    logic signed [TRIG_W-1:0] s;
  } snap_t;

  function automatic logic signed [ACC_W-1:0] to_acc(input logic signed [POS_W-1:0] v);
    return {{(ACC_W-POS_W){v[POS_W-1]}}, v};
  endfunction

  function automatic logic signed [A_W-1:0] trig_op(input logic signed [TRIG_W-1:0] v);
    return {{(A_W-TRIG_W){v[TRIG_W-1]}}, v};
  endfunction

  function automatic logic signed [A_W-1:0] pos_op(input logic signed [POS_W-1:0] v);
    return {v[POS_W-1], v};
  endfunction

  function automatic logic signed [TRIG_W-1:0] neg_trig(input logic signed [TRIG_W-1:0] v);
    return (v == TRIG_MIN) ? TRIG_MAX : -v;
  endfunction

  // Dot products of unit vectors stay within Q1.14; clamp guards rounding.
  function automatic logic signed [TRIG_W-1:0] sat_trig(input logic signed [ACC_W-1:0] v);
    if (v > TRIG_HI) return TRIG_MAX;
    if (v < TRIG_LO) return TRIG_MIN;
    return v[TRIG_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
    if (v == ACC_MIN) return ACC_MAX;
    return v[ACC_W-1] ? -v : v;
  endfunction

  function automatic logic [POS_W-1:0] sat_depth(input logic signed [ACC_W-1:0] v);
    return (v > DEPTH_HI) ? POS_MAX : v[POS_W-1:0];
  endfunction

  state_e                   state;
  logic [2:0]               step;
  axis_e                    k;
  snap_t                    snap_a, snap_b;
  logic signed [A_W-1:0]    tx_r, ty_r;
  logic signed [ACC_W-1:0]  d_r, min_r;
  logic signed [TRIG_W-1:0] un_r, vn_r;
  axis_e                    min_ax;

  logic signed [TRIG_W-1:0] nx, ny;
  logic signed [POS_W-1:0]  own_ext;
  snap_t                    oth;
  logic                     mac_en, mac_clr, mac_abs;
  logic signed [A_W-1:0]    mac_a;
  logic signed [TRIG_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_acc, mac_acc_nxt;
  logic signed [ACC_W-1:0]  r_sum, d_abs, pen, new_min;
  logic                     separated, better;
  axis_e                    new_ax;

  always_comb begin
    nx      = snap_a.c;
    ny      = snap_a.s;
    own_ext = snap_a.hw;
    oth     = snap_b;
    unique case (k)
      AX_AU: begin nx = snap_a.c;           ny = snap_a.s; own_ext = snap_a.hw; oth = snap_b; end
      AX_AV: begin nx = neg_trig(snap_a.s); ny = snap_a.c; own_ext = snap_a.hh; oth = snap_b; end
      AX_BU: begin nx = snap_b.c;           ny = snap_b.s; own_ext = snap_b.hw; oth = snap_a; end
      AX_BV: begin nx = neg_trig(snap_b.s); ny = snap_b.c; own_ext = snap_b.hh; oth = snap_a; end
    endcase

    // Step schedule: d over T, then other.u . n, other.v . n, then r_other.
    mac_en  = (state == ST_AXIS);
    mac_clr = 1'b0;
    mac_abs = 1'b0;
    mac_a   = tx_r;
    mac_b   = nx;
    unique case (step)
      3'd0: begin mac_clr = 1'b1; mac_a = tx_r;                     mac_b = nx; end
      3'd1: begin                 mac_a = ty_r;                     mac_b = ny; end
      3'd2: begin mac_clr = 1'b1; mac_a = trig_op(oth.c);           mac_b = nx; end
      3'd3: begin                 mac_a = trig_op(oth.s);           mac_b = ny; end
      3'd4: begin mac_clr = 1'b1; mac_a = trig_op(neg_trig(oth.s)); mac_b = nx; end
      3'd5: begin                 mac_a = trig_op(oth.c);           mac_b = ny; end
      3'd6: begin mac_clr = 1'b1; mac_abs = 1'b1; mac_a = pos_op(oth.hw); mac_b = un_r; end
      3'd7: begin                 mac_abs = 1'b1; mac_a = pos_op(oth.hh); mac_b = vn_r; end
    endcase

    // Evaluated on the last step, where acc_nxt already holds r_other.
    r_sum     = to_acc(own_ext) + mac_acc_nxt;
    d_abs     = abs_acc(d_r);
    separated = (d_abs > r_sum);
    pen       = r_sum - d_abs;
    better    = (pen < min_r);
    new_min   = better ? pen : min_r;
    new_ax    = better ? k : min_ax;
  end

  sat_mac #(
    .A_W  (A_W),
    .B_W  (TRIG_W),
    .ACC_W(ACC_W),
    .FRAC (TRIG_FRAC)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (mac_en),
    .clr    (mac_clr),
    .abs_b  (mac_abs),
    .a      (mac_a),
    .b      (mac_b),
    .acc    (mac_acc),
    .acc_nxt(mac_acc_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      step      <= '0;
      k         <= AX_AU;
      snap_a    <= '0;
      snap_b    <= '0;
      tx_r      <= '0;
      ty_r      <= '0;
      d_r       <= '0;
      un_r      <= '0;
      vn_r      <= '0;
      min_r     <= '0;
      min_ax    <= AX_AU;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.hit   <= 1'b0;
      bus.axis  <= '0;
      bus.depth <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            snap_a   <= '{x: bus.a_x, y: bus.a_y, hw: bus.a_hw, hh: bus.a_hh,
                          c: bus.a_cos, s: bus.a_sin};
            snap_b   <= '{x: bus.b_x, y: bus.b_y, hw: bus.b_hw, hh: bus.b_hh,
                          c: bus.b_cos, s: bus.b_sin};
            bus.busy <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_r   <= pos_op(snap_b.x) - pos_op(snap_a.x);
          ty_r   <= pos_op(snap_b.y) - pos_op(snap_a.y);
          min_r  <= ACC_MAX;
          min_ax <= AX_AU;
          k      <= AX_AU;
          step   <= '0;
          state  <= ST_AXIS;
        end
        ST_AXIS: begin
          step <= step + 3'd1;
          if (step == S_D)  d_r  <= mac_acc;
          if (step == S_UN) un_r <= sat_trig(mac_acc);
          if (step == S_VN) vn_r <= sat_trig(mac_acc);
          if (step == S_LAST) begin
            if (separated) begin
              bus.hit   <= 1'b0;
              bus.axis  <= '0;
              bus.depth <= '0;
              bus.done  <= 1'b1;
              bus.busy  <= 1'b0;
              state     <= ST_DONE;
            end else begin
              min_r  <= new_min;
              min_ax <= new_ax;
              if (k == AX_BV) begin
                bus.hit   <= 1'b1;
                bus.axis  <= new_ax;
                bus.depth <= sat_depth(new_min);
                bus.done  <= 1'b1;
                bus.busy  <= 1'b0;
                state     <= ST_DONE;
              end else begin
                k <= axis_e'(k + 2'd1);
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obb_collider.sv
// Directed bench for obb_collider: hand-computed SAT cases, latency,
// handshake drop rules and mid-run reset.
module tb_obb_collider;
  import obb_col_pkg::*;

  localparam int Q   = 32;     // Q11.5 scale
  localparam int ONE = 16384;  // Q1.14 unity
  localparam int R45 = 11585;  // cos/sin of 45 degrees

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  obb_collider_if #(.POS_W(16), .TRIG_W(16)) bus ();

  obb_collider #(.POS_W(16), .TRIG_W(16), .ACC_W(40)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic box_t mk(input int x, input int y, input int hw, input int hh,
                              input int c, input int s);
    return '{x: pos_t'(x), y: pos_t'(y), hw: pos_t'(hw), hh: pos_t'(hh),
             cos: trig_t'(c), sin: trig_t'(s)};
  endfunction

  task automatic drive(input box_t a, input box_t b);
    bus.a_x = a.x;  bus.a_y = a.y;  bus.a_hw = a.hw;  bus.a_hh = a.hh;
    bus.a_cos = a.cos;  bus.a_sin = a.sin;
    bus.b_x = b.x;  bus.b_y = b.y;  bus.b_hw = b.hw;  bus.b_hh = b.hh;
    bus.b_cos = b.cos;  bus.b_sin = b.sin;
  endtask

  // Start in cycle 0, then scramble the inputs to prove only the snapshot counts.
  task automatic launch(input box_t a, input box_t b);
    @(negedge clk);
    drive(a, b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drive(box_t'({$urandom, $urandom, $urandom}), box_t'({$urandom, $urandom, $urandom}));
    cyc = 1;
  endtask

  task automatic wait_done(input int poke_cyc, output int lat);
    lat = -1;
    while (cyc <= 60) begin
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
      bus.start = (cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic run(input string name, input box_t a, input box_t b, input int poke_cyc,
                     input int e_lat, input int e_hit, input int e_axis, input int e_depth);
    int lat;
    int cnt0;
    launch(a, b);
    cnt0 = done_cnt;
    check({name, " busy@1"}, bus.busy, 1);
    wait_done(poke_cyc, lat);
    check({name, " done cycle"}, lat, e_lat);
    check({name, " hit"}, bus.hit, e_hit);
    check({name, " axis"}, bus.axis, e_axis);
    check({name, " depth"}, bus.depth, e_depth);
    check({name, " busy@done"}, bus.busy, 0);
    @(negedge clk);
    check({name, " done pulse"}, bus.done, 0);
    repeat (40) @(negedge clk);
    check({name, " done count"}, done_cnt - cnt0, 1);
    check({name, " hit held"}, bus.hit, e_hit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    box_t a0, a1;
    int cnt0;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    drive('0, '0);
    repeat (3) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset hit", bus.hit, 0);
    check("reset axis", bus.axis, 0);
    check("reset depth", bus.depth, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    a0 = mk(100*Q, 100*Q, 10*Q, 10*Q, ONE, 0);
    a1 = mk(0, 0, 10*Q, 10*Q, ONE, 0);

    run("t1 coincident", a0, mk(100*Q, 100*Q, 10*Q, 10*Q, ONE, 0), 0, MAX_LAT, 1, 0, 640);
    run("t2 separated", a0, mk(130*Q, 100*Q, 10*Q, 10*Q, ONE, 0), 0, 10, 0, 0, 0);
    run("t3 touching", a0, mk(120*Q, 100*Q, 10*Q, 10*Q, ONE, 0), 0, MAX_LAT, 1, 0, 0);
    run("t4 rotated", a1, mk(24*Q, 24*Q, 10*Q, 10*Q, R45, R45), 0, 26, 0, 0, 0);
    run("t5 left", a0, mk(70*Q, 100*Q, 10*Q, 10*Q, ONE, 0), 0, 10, 0, 0, 0);
    run("t7 vaxis", a0, mk(100*Q, 110*Q, 10*Q, 10*Q, ONE, 0), 0, MAX_LAT, 1, 1, 320);
    run("t8 depth sat", mk(0, 0, 20000, 20000, ONE, 0), mk(0, 0, 20000, 20000, ONE, 0),
        0, MAX_LAT, 1, 0, 32767);
    run("t6a restart", a0, a0, 5, MAX_LAT, 1, 0, 640);

    // Mid-run reset: outputs clear at once and the aborted run never reports.
    launch(a0, a0);
    cnt0 = done_cnt;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("t6b busy", bus.busy, 0);
    check("t6b done", bus.done, 0);
    check("t6b hit", bus.hit, 0);
    check("t6b axis", bus.axis, 0);
    check("t6b depth", bus.depth, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6b no done", done_cnt - cnt0, 0);

    run("t6c after reset", a0, a0, 0, MAX_LAT, 1, 0, 640);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obb_collider.md
# obb_collider

Pairwise oriented-bounding-box collision detector using the separating-axis test (SAT). It sits between the two `obb_reg` instances and `obb_updater`. At start it snapshots both boxes' centre, half-extents and orientation trig, then evaluates the four candidate axes sequentially on one shared multiply-accumulate unit. It reports hit, minimum-penetration axis and depth, which the updater uses for collision response on the next frame.

## Interface
Parameters:
- `POS_W`, 16: position/extent width, signed Q11.5.
- `TRIG_W`, 16: cos/sin width, signed Q1.14.
- `ACC_W`, 40: MAC accumulator width.

Ports:
- `clk` in 1: single clock (`vsync` in synthesis, `Clk` in simulation).
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; ignored while `busy`.
- `a_x`, `a_y`, `b_x`, `b_y` in POS_W: box centres.
- `a_hw`, `a_hh`, `b_hw`, `b_hh` in POS_W: half-extents, non-negative.
- `a_cos`, `a_sin`, `b_cos`, `b_sin` in TRIG_W: orientation from the juicer.
- `busy` out 1: test in progress.
- `done` out 1: one-cycle pulse when results are valid.
- `hit` out 1: boxes overlap or touch.
- `axis` out 2: min-penetration axis (0 A.u, 1 A.v, 2 B.u, 3 B.v).
- `depth` out POS_W: penetration depth, Q11.5, ≥0.

## Operation
- Axes: A.u=(a_cos,a_sin), A.v=(−a_sin,a_cos); likewise for B.
- T=(b_x−a_x, b_y−a_y), computed at POS_W+1 bits.
- States: IDLE → LOAD → AXIS (8 MAC steps × up to 4 axes) → DONE → IDLE.
- IDLE: when `start` is high, snapshot all inputs, assert `busy` and go to LOAD.
- LOAD: compute T, clear the running minimum, set axis index k=0.
- AXIS, per axis n, steps 0–7:
  - Steps 0–1: d = Tx·nx + Ty·ny.
  - Steps 2–5: dot products of the other box's u and v with n.
  - Steps 6–7: r_other = hw·|u·n| + hh·|v·n|.
  - Own radius r_own is the own extent (hw for a u-axis, hh for a v-axis); it is not multiplied.
- Scaling: every product of a Q11.5 and a Q1.14 operand is arithmetic-shifted right by 14 before accumulation, so the accumulator holds Q11.5 at ACC_W. |x| saturates on the most-negative value.
- Separation test: separated iff |d| > r_own + r_other (strict). If separated, set `hit`=0 and go straight to DONE (early exit); `axis` and `depth` are set to 0.
- Otherwise compute pen = r_own + r_other − |d|. If pen < running minimum, update the minimum and its axis; ties keep the lower index.
- After axis 3 with no separation: `hit`=1, `axis`/`depth` = running minimum. `depth` saturates at 2^(POS_W−1)−1.
- DONE: pulse `done`, deassert `busy`. Outputs hold until the next DONE.

## Timing
- Reset values: `busy`=0, `done`=0, `hit`=0, `axis`=0, `depth`=0; state IDLE.
- Reset asserted mid-operation aborts immediately to reset values; there is no `done` for the aborted run.
- Start sampled at cycle 0: LOAD at cycle 1; axis k occupies cycles 2+8k … 9+8k.
- `done` is high at cycle 10, 18, 26 (early exit on axis 0, 1, 2) or 34 (separated on axis 3, or full overlap).
- `busy` is high from cycle 1 through the cycle before `done`.
- `start` during `busy` or in the DONE cycle is dropped, with no queuing. `start` in the cycle after DONE is accepted.
- Inputs may change freely after cycle 0; only the snapshot is used.

## Structure
- Package `obb_col_pkg`:
  - Typedefs `pos_t` (signed Q11.5) and `trig_t` (signed Q1.14).
  - `box_t` struct {x, y, hw, hh, cos, sin}.
  - `axis_e` enum {AX_AU, AX_AV, AX_BU, AX_BV}.
  - State enum.
  - Constants TRIG_FRAC=14, STEPS_PER_AXIS=8, MAX_LAT=34.
- Sub-module `sat_mac`: registered signed multiply, >>>TRIG_FRAC, then accumulate with clear and abs-operand select. Single-cycle issue.
- The top FSM owns operand sequencing and the min/compare logic.

## Test plan
1. Both boxes at (100,100), hw=hh=10, cos=1.0, sin=0 → `done` at cycle 34, hit=1, axis=0, depth=20.0.
2. A at (100,100), B at (130,100), both 10×10 axis-aligned → `done` at cycle 10, hit=0, axis=0, depth=0.
3. Touching: B at (120,100) → hit=1, depth=0.0, axis=0 (tie with axis 2 resolved to the lower index).
4. Rotated case:
   - Setup: A at (0,0), axis-aligned 10×10; B at (24,24), 10×10, cos=sin=11585 (≈45°).
   - Required: axes 0–1 pass with pen≈0.14; separated on axis 2; `done` at cycle 26, hit=0.
5. Sign handling: repeat test 2 with B at (70,100) (B left of A) → identical result.
6. Handshake and reset:
   - `start` pulsed again at cycle 5 → ignored; single `done` at cycle 34.
   - Separate run: `reset_n` low at cycle 15 → all outputs 0 and no `done`.
   - `start` after reset release → normal result.
